// File: rtl/pipeline_hazard_ctrl.sv
// IF/ID and PC write control for the DLX pipeline: load-use stalls, branch flushes, imem waits, HALT.
// Define HAZARD_STATS_EN to add saturating stall_count/flush_count statistics outputs.
//
// state  | meaning
// RUN    | normal issue; load-use, imem wait and HALT requests resolved here
// FLUSH  | IF/ID held flushed for the remaining cycles after a taken branch
// HALT   | HALT instruction reached ID; waits for resume
// FAULT  | imem stayed busy too long; waits for resume
module pipeline_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int WAIT_TIMEOUT = 15
`ifdef HAZARD_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_halt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic             imem_busy,
  input  logic             resume,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             halted,
  output logic             fault,
  output logic [1:0]       state
`ifdef HAZARD_STATS_EN
  , output logic [CNT_W-1:0] stall_count
  , output logic [CNT_W-1:0] flush_count
`endif
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_FLUSH = 2'b01,
    ST_HALT  = 2'b10,
    ST_FAULT = 2'b11
  } state_t;

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] WAIT_LAST    = 8'(WAIT_TIMEOUT - 1);

  state_t     state_q;
  logic [2:0] flush_cnt;
  logic [7:0] wait_cnt;
  logic       fault_q;
  logic       lu;

  assign lu = ex_mem_read && (ex_rt != 5'd0) &&
              ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  assign state  = state_q;
  assign fault  = fault_q;
  assign halted = (state_q == ST_HALT) || (state_q == ST_FAULT);

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (ex_branch_taken) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (lu || imem_busy || id_halt) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
        end
      end
      ST_FLUSH: begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        pc_write     = !imem_busy;
      end
      ST_HALT, ST_FAULT: begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_RUN;
      flush_cnt <= 3'd0;
      wait_cnt  <= 8'd0;
      fault_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (!imem_busy) wait_cnt <= 8'd0;
          if (ex_branch_taken) begin
            flush_cnt <= FLUSH_RELOAD;
            if (FLUSH_CYCLES > 1) state_q <= ST_FLUSH;
          end else if (!lu) begin
            // wait_cnt only advances on cycles where imem_busy is the deciding stall
            if (imem_busy) begin
              if (wait_cnt == WAIT_LAST) begin
                state_q  <= ST_FAULT;
                fault_q  <= 1'b1;
                wait_cnt <= 8'd0;
              end else if (wait_cnt != 8'hFF) begin
                wait_cnt <= wait_cnt + 8'd1;
              end
            end else if (id_halt) begin
              state_q <= ST_HALT;
            end
          end
        end
        ST_FLUSH: begin
          if (!imem_busy) wait_cnt <= 8'd0;
          if (ex_branch_taken) begin
            flush_cnt <= FLUSH_RELOAD;
            if (FLUSH_CYCLES == 1) state_q <= ST_RUN;
          end else if (flush_cnt <= 3'd1) begin
            flush_cnt <= 3'd0;
            state_q   <= ST_RUN;
          end else begin
            flush_cnt <= flush_cnt - 3'd1;
          end
        end
        ST_HALT, ST_FAULT: begin
          if (resume) begin
            state_q  <= ST_RUN;
            fault_q  <= 1'b0;
            wait_cnt <= 8'd0;
          end
        end
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if ((state_q == ST_RUN) && !pc_write && (stall_count != '1))
        stall_count <= stall_count + CNT_W'(1);
      if (if_id_flush && (flush_count != '1))
        flush_count <= flush_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (FLUSH_CYCLES=3, WAIT_TIMEOUT=4) with an expected-output queue.
module tb_pipeline_hazard_ctrl;
  localparam int FC = 3;
  localparam int WT = 4;
  localparam int CW = 16;

  // {state[1:0], pc_write, if_id_write, if_id_flush, id_ex_bubble, halted, fault}
  localparam logic [7:0] E_NORM  = 8'b00_1100_00;
  localparam logic [7:0] E_STALL = 8'b00_0001_00;
  localparam logic [7:0] E_BR    = 8'b00_1111_00;
  localparam logic [7:0] E_FL    = 8'b01_1111_00;
  localparam logic [7:0] E_FLB   = 8'b01_0111_00;
  localparam logic [7:0] E_HLT   = 8'b10_0001_10;
  localparam logic [7:0] E_FLT   = 8'b11_0001_11;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic id_uses_rt, id_halt, ex_mem_read, ex_branch_taken, imem_busy, resume;
  logic pc_write, if_id_write, if_id_flush, id_ex_bubble, halted, fault;
  logic [1:0] state;
`ifdef HAZARD_STATS_EN
  logic [CW-1:0] stall_count, flush_count;
  int es = 0;
  int ef = 0;
`endif

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  string tag_q[$];
  logic [7:0] obs;

  always #5 clk = ~clk;

  assign obs = {state, pc_write, if_id_write, if_id_flush, id_ex_bubble, halted, fault};

  pipeline_hazard_ctrl #(
    .FLUSH_CYCLES(FC),
    .WAIT_TIMEOUT(WT)
`ifdef HAZARD_STATS_EN
    , .CNT_W(CW)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .id_rs(id_rs),
    .id_rt(id_rt),
    .id_uses_rt(id_uses_rt),
    .id_halt(id_halt),
    .ex_mem_read(ex_mem_read),
    .ex_rt(ex_rt),
    .ex_branch_taken(ex_branch_taken),
    .imem_busy(imem_busy),
    .resume(resume),
    .pc_write(pc_write),
    .if_id_write(if_id_write),
    .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble),
    .halted(halted),
    .fault(fault),
    .state(state)
`ifdef HAZARD_STATS_EN
    , .stall_count(stall_count)
    , .flush_count(flush_count)
`endif
  );

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
    id_uses_rt = 1'b0; id_halt = 1'b0; ex_mem_read = 1'b0;
    ex_branch_taken = 1'b0; imem_busy = 1'b0; resume = 1'b0;
  endtask

  task automatic nx();
    @(negedge clk);
    idle();
  endtask

  task automatic check_out();
    logic [7:0] e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", t, obs, e);
    end
`ifdef HAZARD_STATS_EN
    if (!reset) begin es = 0; ef = 0; end
    total++;
    assert (stall_count === CW'(es)) else begin
      bad++;
      $error("FAIL %s_stall_count observed=%0d expected=%0d", t, stall_count, es);
    end
    total++;
    assert (flush_count === CW'(ef)) else begin
      bad++;
      $error("FAIL %s_flush_count observed=%0d expected=%0d", t, flush_count, ef);
    end
    // counters pick up this cycle's outputs at the next rising edge
    if (reset) begin
      if (e[7:6] == 2'b00 && !e[5]) es++;
      if (e[3]) ef++;
    end
`endif
  endtask

  task automatic expect_out(input string tag, input logic [7:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #1;
    check_out();
  endtask

  initial begin
    idle();
    nx(); expect_out("reset", E_NORM);
    reset = 1'b1;
    nx(); expect_out("normal", E_NORM);

    nx(); ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; expect_out("lu_rs", E_STALL);
    nx(); ex_rt = 5'd5; id_rs = 5'd5; expect_out("lu_clear", E_NORM);
    nx(); ex_mem_read = 1'b1; ex_rt = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b1; id_rs = 5'd3;
    expect_out("lu_rt", E_STALL);
    nx(); ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; expect_out("lu_r0", E_NORM);
    nx(); ex_mem_read = 1'b1; ex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd3; expect_out("lu_rt_unused", E_NORM);

    nx(); ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
    expect_out("br_lu", E_BR);
    nx(); ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; expect_out("fl1_lu_ign", E_FL);
    nx(); id_halt = 1'b1; expect_out("fl2_halt_ign", E_FL);
    nx(); expect_out("fl_done", E_NORM);

    nx(); ex_branch_taken = 1'b1; expect_out("br2", E_BR);
    nx(); imem_busy = 1'b1; expect_out("fl_busy", E_FLB);
    nx(); ex_branch_taken = 1'b1; expect_out("fl_reload", E_FL);
    nx(); expect_out("fl_reload1", E_FL);
    nx(); expect_out("fl_reload2", E_FL);
    nx(); expect_out("fl_reload_done", E_NORM);

    nx(); ex_branch_taken = 1'b1; imem_busy = 1'b1; expect_out("br_over_busy", E_BR);
    nx(); expect_out("fl_after_busy_br", E_FL);
    nx(); expect_out("fl_after_busy_br2", E_FL);
    nx(); imem_busy = 1'b1; id_halt = 1'b1; expect_out("busy_over_halt", E_STALL);
    nx(); expect_out("busy_over_halt_run", E_NORM);

    for (int i = 0; i < 3; i++) begin nx(); imem_busy = 1'b1; expect_out("busy_a", E_STALL); end
    nx(); expect_out("busy_gap", E_NORM);
    for (int i = 0; i < 3; i++) begin nx(); imem_busy = 1'b1; expect_out("busy_b", E_STALL); end
    nx(); expect_out("busy_no_fault", E_NORM);

    for (int i = 0; i < 4; i++) begin nx(); imem_busy = 1'b1; expect_out("to_busy", E_STALL); end
    nx(); imem_busy = 1'b1; expect_out("to_fault", E_FLT);
    nx(); ex_branch_taken = 1'b1; id_halt = 1'b1; expect_out("fault_hold", E_FLT);
    nx(); resume = 1'b1; expect_out("fault_resume", E_FLT);
    nx(); expect_out("fault_cleared", E_NORM);

    nx(); id_halt = 1'b1; expect_out("halt_req", E_STALL);
    for (int i = 0; i < 20; i++) begin
      nx();
      ex_branch_taken = 1'($urandom_range(0, 1));
      imem_busy = 1'($urandom_range(0, 1));
      id_halt = 1'($urandom_range(0, 1));
      ex_mem_read = 1'($urandom_range(0, 1));
      ex_rt = 5'($urandom_range(0, 31));
      id_rs = ex_rt;
      expect_out("halt_hold", E_HLT);
    end
    nx(); resume = 1'b1; expect_out("halt_resume_cyc", E_HLT);
    nx(); expect_out("halt_resumed", E_NORM);

    nx(); ex_branch_taken = 1'b1; expect_out("br3", E_BR);
    nx(); expect_out("fl_pre_rst", E_FL);
    nx(); reset = 1'b0; expect_out("rst_mid_flush", E_NORM);
    reset = 1'b1;
    nx(); expect_out("after_rst_flush", E_NORM);

    for (int i = 0; i < 4; i++) begin nx(); imem_busy = 1'b1; expect_out("to2_busy", E_STALL); end
    nx(); expect_out("flt_pre_rst", E_FLT);
    nx(); reset = 1'b0; expect_out("rst_mid_fault", E_NORM);
    reset = 1'b1;
    nx(); expect_out("after_rst_fault", E_NORM);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
